cuadrado_32: RTL and testbench
==============================

Name: cuadrado_32

Overview:
- Sequential squarer that inverts the square-root path: it rebuilds the radicand from a root and remainder as RR = Q*Q + R.
- Uses a shift-add multiplier, one multiplier bit per clock, with the same init/done handshake as the root block.
- Sits beside the 32-bit root datapath. It feeds results back for self-check and regenerates radicands for the bench.
- Also flags remainders that could not come from a valid integer square root (R > 2Q).

Parameters:
- WIDTH, 16, root width in bits. Remainder is WIDTH+1 bits; radicand is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- init  input  1  start request; sampled only in IDLE
- in_Q  input  WIDTH  root operand
- in_R  input  WIDTH+1  remainder operand
- out_RR  output  2*WIDTH  reconstructed radicand (Q*Q + R) mod 2^(2*WIDTH)
- err  output  1  remainder invalid (R > 2Q) or sum overflowed; valid while done=1
- busy  output  1  high from operand capture until the result is posted
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset:
  - rst=1 at a rising edge forces state=IDLE and clears out_RR, err, busy, done and all internal registers.
  - This applies in any state, including mid-calculation. No partial result is posted.
- FSM states: IDLE, CALC, POST.
- IDLE:
  - busy=0.
  - If init=1 at edge k, capture the operands at that edge:
    - A = zero-extended in_Q (2*WIDTH bits)
    - B = in_Q
    - ACC = zero-extended in_R (2*WIDTH+1 bits)
    - cnt = 0
    - invalid = (in_R > 2*in_Q), evaluated at full width
  - Move to CALC and set busy=1 at edge k.
- CALC, one iteration per edge:
  - If B[0]=1, ACC = ACC + A.
  - Then A = A<<1, B = B>>1, cnt = cnt + 1.
  - After WIDTH iterations, i.e. at edge k+WIDTH when cnt reaches WIDTH, go to POST.
- POST, single cycle:
  - At edge k+WIDTH+1: out_RR = ACC[2*WIDTH-1:0], err = invalid | ACC[2*WIDTH], done=1, busy=0.
  - Next state is IDLE.
- Latency: init sampled at edge k gives done high during the cycle after edge k+WIDTH+1, which is WIDTH+2 edges after sampling.
- done is high for exactly one cycle and drops at the next edge.
- out_RR and err hold their values until the next POST or reset. err is only meaningful while done=1.
- init=1 while busy=1 (CALC or POST) is ignored and not queued.
- init=1 in the cycle right after done, with the FSM back in IDLE, starts a new operation. Minimum issue interval is WIDTH+2 cycles.
- in_Q and in_R may change after capture without affecting the result.
- Arithmetic:
  - ACC carries one extra bit.
  - Q = 2^WIDTH-1 with R = 2Q gives exactly 2^(2*WIDTH)-1 with no overflow.
  - Any R > 2Q sets err. An overflowed sum wraps modulo 2^(2*WIDTH).
- Zero operands: Q=0 still runs the full WIDTH iterations (fixed latency); the result is R.
- Simultaneous rst=1 and init=1: reset wins and the operands are not captured.

Test Plan:
- Reset, then init with Q=0, R=0 → done exactly WIDTH+2 edges after init was sampled (18 for WIDTH=16); out_RR=0, err=0, done width 1 cycle.
- Q=3, R=2 → out_RR=11, err=0. Then Q=255, R=510 → out_RR=65535, err=0.
- Q=65535, R=131070 → out_RR=0xFFFFFFFF, err=0. Then Q=65535, R=131071 → out_RR=0x00000000, err=1. Then Q=4, R=9 → out_RR=25, err=1 (invalid remainder).
- Start Q=10, R=0; pulse init with Q=7 at cycle 5 of CALC → ignored; result 100. Then init in the cycle right after done with Q=7, R=1 → result 50.
- Start Q=1000, R=5; assert rst at CALC cycle 8 → next cycle state IDLE, busy=0, done=0, out_RR=0. No done pulse follows. A fresh init with Q=1000, R=5 → 1000005.
- Random sweep of 1000 (Q, R) pairs with R ≤ 2Q, compared against the reference model Q*Q+R → all match, err=0. Outputs are also checked against the root block by feeding RR back: root returns the original Q, R.

Source files
------------

// File: rtl/cuadrado_32.sv
// Sequential squarer: rebuilds a radicand RR = Q*Q + R with a one-bit-per-clock
// shift-add multiplier and flags remainders no integer square root can produce.
module cuadrado_32 #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init,
   input  logic [WIDTH-1:0]   in_Q,
   input  logic [WIDTH:0]     in_R,
   output logic [2*WIDTH-1:0] out_RR,
   output logic               err,
   output logic               busy,
   output logic               done
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      POST = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               invalid_q, invalid_d;
   logic [2*WIDTH-1:0] out_rr_q, out_rr_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (init) state_d = CALC;
         CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = POST;
         POST:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered outputs; ACC keeps one carry bit so overflow is visible.
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      invalid_d = invalid_q;
      out_rr_d  = out_rr_q;
      err_d     = err_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (init) begin
               a_d       = {{WIDTH{1'b0}}, in_Q};
               b_d       = in_Q;
               acc_d     = {{WIDTH{1'b0}}, in_R};
               cnt_d     = '0;
               invalid_d = (in_R > {in_Q, 1'b0});
               busy_d    = 1'b1;
            end
         end
         CALC: begin
            if (b_q[0]) acc_d = acc_q + {1'b0, a_q};
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
         end
         POST: begin
            out_rr_d = acc_q[2*WIDTH-1:0];
            err_d    = invalid_q | acc_q[2*WIDTH];
            done_d   = 1'b1;
            busy_d   = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         invalid_q <= 1'b0;
         out_rr_q  <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         invalid_q <= invalid_d;
         out_rr_q  <= out_rr_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign out_RR = out_rr_q;
   assign err    = err_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_cuadrado_32.sv
// Directed and random bench for cuadrado_32 (WIDTH=16): latency, boundaries,
// busy-time init rejection, mid-calculation reset and root round-trip.
module tb_cuadrado_32;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           init = 1'b0;
   logic [W-1:0]   in_Q = '0;
   logic [W:0]     in_R = '0;
   logic [2*W-1:0] out_RR;
   logic           err, busy, done;

   int checks = 0;
   int failures = 0;

   cuadrado_32 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .init(init), .in_Q(in_Q), .in_R(in_R),
      .out_RR(out_RR), .err(err), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Integer square root used to confirm RR maps back to the original (Q, R).
   function automatic void isqrt(input logic [31:0] v, output logic [15:0] q,
                                 output logic [16:0] r);
      longint unsigned t, c;
      t = 0;
      for (int i = 15; i >= 0; i--) begin
         c = t | (64'd1 << i);
         if (c * c <= longint'(v)) t = c;
      end
      q = t[15:0];
      r = 17'(longint'(v) - t * t);
   endfunction

   // Issue one operation from IDLE and wait (bounded) for done; lat counts edges
   // from the sampling edge of init up to and including the edge raising done.
   task automatic run_op(input logic [W-1:0] q, input logic [W:0] r,
                         output logic [2*W-1:0] rr, output logic e, output int lat);
      in_Q = q; in_R = r; init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0; in_Q = '1; in_R = '1;
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL op_timeout q=%0d r=%0d no done after %0d edges", q, r, lat);
      end
      rr = out_RR;
      e  = err;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out_RR, err, busy, done} !== '0) begin
         failures++;
         $display("FAIL reset_state got rr=%h err=%b busy=%b done=%b want all 0",
                  out_RR, err, busy, done);
      end
      init = 1'b1; in_Q = 16'd9; in_R = 17'd1;
      @(posedge clk); #1;
      init = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_beats_init got busy=%b want 0", busy);
      end
   endtask

   task automatic test_zero_latency();
      logic [2*W-1:0] rr; logic e; int lat;
      run_op(16'd0, 17'd0, rr, e, lat);
      checks++;
      if (lat !== W + 2) begin
         failures++;
         $display("FAIL latency got %0d want %0d", lat, W + 2);
      end
      checks++;
      if (rr !== 32'd0 || e !== 1'b0) begin
         failures++;
         $display("FAIL zero_op got rr=%0d err=%b want 0 0", rr, e);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL done_width got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_vectors();
      logic [W-1:0]   qv [5] = '{16'd3, 16'd255, 16'd65535, 16'd65535, 16'd4};
      logic [W:0]     rv [5] = '{17'd2, 17'd510, 17'd131070, 17'd131071, 17'd9};
      logic [2*W-1:0] ev [5] = '{32'd11, 32'd65535, 32'hFFFF_FFFF, 32'h0, 32'd25};
      logic           ee [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [2*W-1:0] rr; logic e; int lat;
      for (int i = 0; i < 5; i++) begin
         run_op(qv[i], rv[i], rr, e, lat);
         checks++;
         if (rr !== ev[i] || e !== ee[i]) begin
            failures++;
            $display("FAIL vector%0d q=%0d r=%0d got rr=%h err=%b want rr=%h err=%b",
                     i, qv[i], rv[i], rr, e, ev[i], ee[i]);
         end
      end
   endtask

   task automatic test_ignore_init();
      logic [2*W-1:0] rr; logic e; int lat;
      in_Q = 16'd10; in_R = 17'd0; init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_in_calc got %b want 1", busy);
      end
      in_Q = 16'd7; in_R = 17'd3; init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (done !== 1'b1 || out_RR !== 32'd100 || err !== 1'b0) begin
         failures++;
         $display("FAIL busy_init_ignored got done=%b rr=%0d err=%b want 1 100 0",
                  done, out_RR, err);
      end
      run_op(16'd7, 17'd1, rr, e, lat);
      checks++;
      if (rr !== 32'd50 || e !== 1'b0 || lat !== W + 2) begin
         failures++;
         $display("FAIL back_to_back got rr=%0d err=%b lat=%0d want 50 0 %0d",
                  rr, e, lat, W + 2);
      end
   endtask

   task automatic test_reset_mid();
      logic [2*W-1:0] rr; logic e; int lat;
      int seen;
      in_Q = 16'd1000; in_R = 17'd5; init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_RR !== 32'd0) begin
         failures++;
         $display("FAIL mid_reset got busy=%b done=%b rr=%0d want 0 0 0",
                  busy, done, out_RR);
      end
      seen = 0;
      repeat (W + 6) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL no_done_after_reset got %0d pulses want 0", seen);
      end
      run_op(16'd1000, 17'd5, rr, e, lat);
      checks++;
      if (rr !== 32'd1000005 || e !== 1'b0) begin
         failures++;
         $display("FAIL after_reset got rr=%0d err=%b want 1000005 0", rr, e);
      end
   endtask

   task automatic test_sweep();
      logic [2*W-1:0] rr, exp_rr; logic e; int lat;
      logic [W-1:0] q, bq; logic [W:0] r, br;
      for (int i = 0; i < 1000; i++) begin
         q = W'($urandom_range(0, 65535));
         r = (W+1)'($urandom_range(0, 2 * int'(q)));
         exp_rr = 32'(longint'(q) * longint'(q) + longint'(r));
         run_op(q, r, rr, e, lat);
         checks++;
         if (rr !== exp_rr || e !== 1'b0) begin
            failures++;
            $display("FAIL sweep q=%0d r=%0d got rr=%0d err=%b want rr=%0d err=0",
                     q, r, rr, e, exp_rr);
         end
         isqrt(rr, bq, br);
         checks++;
         if (bq !== q || br !== r) begin
            failures++;
            $display("FAIL root_back rr=%0d got q=%0d r=%0d want q=%0d r=%0d",
                     rr, bq, br, q, r);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_latency();
      test_vectors();
      test_ignore_init();
      test_reset_mid();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
